// File: rtl/conv2d_1x1_mc.sv
// Multi-channel 1x1 convolution: serial channel beats, 3-stage multiply/accumulate/round-saturate pipeline.
// Optional runtime bias register and ports enabled by defining CONV1X1_BIAS_EN.
module conv2d_1x1_mc #(
    parameter int IN_CH        = 3,
    parameter int WEIGHT_WIDTH = 16,
    parameter int FRAC_BITS    = 8,
    parameter int ACC_WIDTH    = 32,
    localparam int CNT_W       = (IN_CH > 1) ? $clog2(IN_CH) : 1
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           En,
    input  logic                           valid_in,
    input  logic [7:0]                     data_in,
    input  logic                           w_we,
    input  logic [CNT_W-1:0]               w_addr,
    input  logic signed [WEIGHT_WIDTH-1:0] w_data,
`ifdef CONV1X1_BIAS_EN
    input  logic                           bias_we,
    input  logic signed [ACC_WIDTH-1:0]    bias_data,
`endif
    output logic                           valid_out,
    output logic [7:0]                     data_out
);

    localparam int PW = 9 + WEIGHT_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) << (FRAC_BITS - 1);

    logic signed [WEIGHT_WIDTH-1:0] w [IN_CH];
    logic signed [ACC_WIDTH-1:0]    bias;

    logic [CNT_W-1:0]      cnt;
    logic                  cnt_last;

    logic                  s1_valid, s1_first, s1_last;
    logic signed [PW-1:0]  s1_prod;

    logic                  s2_valid, s2_last;
    logic signed [ACC_WIDTH-1:0] acc, acc_next, rounded;

    logic                  out_valid;
    logic [7:0]            sat;

    // Weight/bias writes ignore En; a write landing on the same edge as a use is seen only by later beats.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int unsigned i = 0; i < IN_CH; i++) w[i] <= '0;
        end else if (w_we && (32'(w_addr) < IN_CH)) begin
            w[w_addr] <= w_data;
        end
    end

`ifdef CONV1X1_BIAS_EN
    always_ff @(posedge Clk) begin
        if (Rst)          bias <= '0;
        else if (bias_we) bias <= bias_data;
    end
`else
    assign bias = '0;
`endif

    assign cnt_last = (cnt == CNT_W'(IN_CH - 1));

    // S1: channel tagging and product
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
        end else if (En) begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_first <= (cnt == '0);
                s1_last  <= cnt_last;
                s1_prod  <= PW'($signed({1'b0, data_in})) * PW'(w[cnt]);
                cnt      <= cnt_last ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // S2: accumulate, reseeding from bias on the first channel of each pixel
    assign acc_next = (s1_first ? bias : acc) + ACC_WIDTH'(s1_prod);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            acc      <= '0;
        end else if (En) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid) acc <= acc_next;
        end
    end

    // S3: round half up, arithmetic shift, clamp to 0..255
    assign rounded = (acc + HALF) >>> FRAC_BITS;

    always_comb begin
        sat = rounded[7:0];
        if (rounded[ACC_WIDTH-1])          sat = '0;
        else if (|rounded[ACC_WIDTH-2:8])  sat = '1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else if (En) begin
            out_valid <= s2_valid & s2_last;
            if (s2_valid && s2_last) data_out <= sat;
        end
    end

    // A pulse frozen by En=0 is held and re-presented once En returns.
    assign valid_out = out_valid & En;

endmodule

// File: tb/tb_conv2d_1x1_mc.sv
// Directed self-checking bench for conv2d_1x1_mc (IN_CH=3, Q8 weights); bias checks when CONV1X1_BIAS_EN is defined.
module tb_conv2d_1x1_mc;

    logic               Clk = 1'b0;
    logic               Rst, En, valid_in, w_we;
    logic [7:0]         data_in;
    logic [1:0]         w_addr;
    logic signed [15:0] w_data;
`ifdef CONV1X1_BIAS_EN
    logic               bias_we;
    logic signed [31:0] bias_data;
`endif
    logic               valid_out;
    logic [7:0]         data_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_val = -1;
    int pv [64];
    int pc [64];

    conv2d_1x1_mc #(
        .IN_CH(3),
        .WEIGHT_WIDTH(16),
        .FRAC_BITS(8),
        .ACC_WIDTH(32)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .En(En),
        .valid_in(valid_in),
        .data_in(data_in),
        .w_we(w_we),
        .w_addr(w_addr),
        .w_data(w_data),
`ifdef CONV1X1_BIAS_EN
        .bias_we(bias_we),
        .bias_data(bias_data),
`endif
        .valid_out(valid_out),
        .data_out(data_out)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    // Record every output pulse away from the active edge.
    always @(negedge Clk) begin
        if (valid_out === 1'b1) begin
            if (pulse_cnt < 64) begin
                pv[pulse_cnt] = int'(data_out);
                pc[pulse_cnt] = cyc;
            end
            last_val = int'(data_out);
            pulse_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] v);
        valid_in = 1'b1;
        data_in  = v;
        tick(1);
        valid_in = 1'b0;
    endtask

    task automatic wr_w(input int a, input logic [15:0] d);
        w_we   = 1'b1;
        w_addr = 2'(a);
        w_data = d;
        tick(1);
        w_we   = 1'b0;
    endtask

    task automatic wr_all(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        wr_w(0, d0);
        wr_w(1, d1);
        wr_w(2, d2);
    endtask

    // Three beats, drain the pipe, expect exactly one new pulse with the given value.
    task automatic pixel(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input int exp);
        int n0;
        n0 = pulse_cnt;
        beat(a);
        beat(b);
        beat(c);
        tick(4);
        check({tag, "_pulses"}, pulse_cnt - n0, 1);
        check({tag, "_val"}, last_val, exp);
    endtask

    initial begin
        int n0;
        int b2b [12];
        b2b = '{100, 100, 100, 255, 255, 255, 1, 1, 1, 3, 1, 2};

        Rst = 1'b1; En = 1'b1; valid_in = 1'b0; data_in = '0;
        w_we = 1'b0; w_addr = '0; w_data = '0;
`ifdef CONV1X1_BIAS_EN
        bias_we = 1'b0; bias_data = '0;
`endif
        tick(2);
        check("rst_valid", int'(valid_out), 0);
        check("rst_data", int'(data_out), 0);
        Rst = 1'b0;

        // Unit weights: latency and hold of the result
        wr_all(16'h0100, 16'h0100, 16'h0100);
        n0 = pulse_cnt;
        beat(10);
        beat(20);
        beat(30);
        check("lat_e0", int'(valid_out), 0);
        tick(1);
        check("lat_e1", int'(valid_out), 0);
        tick(1);
        check("lat_e2_valid", int'(valid_out), 1);
        check("lat_e2_data", int'(data_out), 60);
        tick(1);
        check("pulse_one_cycle", int'(valid_out), 0);
        check("data_held", int'(data_out), 60);
        check("lat_pulses", pulse_cnt - n0, 1);

        // Saturation high and low
        wr_all(16'h0200, 16'h0200, 16'h0200);
        pixel("sat_hi", 200, 200, 200, 255);
        wr_all(16'hFF00, 16'hFF00, 16'hFF00);
        pixel("sat_lo", 5, 5, 5, 0);

        // Round half up
        wr_all(16'h0080, 16'h0000, 16'h0000);
        pixel("round_1p5", 3, 99, 77, 2);
        pixel("round_0p5", 1, 200, 13, 1);

        // Out-of-range weight address must not alias onto a real weight
        wr_all(16'h0100, 16'h0100, 16'h0100);
        wr_w(3, 16'h7FFF);
        pixel("addr_oob", 10, 20, 30, 60);

        // Same-edge write and use: channel 0 still sees the old weight
        valid_in = 1'b1; data_in = 10;
        w_we = 1'b1; w_addr = 2'd0; w_data = 16'h0200;
        tick(1);
        valid_in = 1'b0; w_we = 1'b0;
        beat(20);
        beat(30);
        tick(4);
        check("same_edge_old", last_val, 60);
        pixel("same_edge_new", 10, 20, 30, 70);

        // Four pixels back-to-back with weights 1.0, 0.5, 0.25
        wr_all(16'h0100, 16'h0080, 16'h0040);
        n0 = pulse_cnt;
        for (int i = 0; i < 12; i++) begin
            valid_in = 1'b1;
            data_in  = 8'(b2b[i]);
            tick(1);
        end
        valid_in = 1'b0;
        tick(5);
        check("b2b_pulses", pulse_cnt - n0, 4);
        if (pulse_cnt - n0 == 4 && n0 + 4 <= 64) begin
            check("b2b_v0", pv[n0],     175);
            check("b2b_v1", pv[n0 + 1], 255);
            check("b2b_v2", pv[n0 + 2], 2);
            check("b2b_v3", pv[n0 + 3], 4);
            for (int k = 1; k < 4; k++)
                check("b2b_gap", pc[n0 + k] - pc[n0 + k - 1], 3);
        end

        // Stall after beat 2 with valid_in asserted on junk data
        wr_all(16'h0100, 16'h0100, 16'h0100);
        n0 = pulse_cnt;
        beat(10);
        beat(20);
        En = 1'b0; valid_in = 1'b1; data_in = 99;
        tick(5);
        check("stall_no_pulse", pulse_cnt - n0, 0);
        valid_in = 1'b0; En = 1'b1;
        beat(30);
        tick(4);
        check("stall_pulses", pulse_cnt - n0, 1);
        check("stall_val", last_val, 60);

        // Stall with a finished result inside the pipe
        n0 = pulse_cnt;
        beat(7);
        beat(8);
        beat(9);
        En = 1'b0;
        tick(4);
        check("stall_out_hold", pulse_cnt - n0, 0);
        En = 1'b1;
        tick(4);
        check("stall_out_pulses", pulse_cnt - n0, 1);
        check("stall_out_val", last_val, 24);

        // Reset mid-pixel discards partial pixel and clears weights
        n0 = pulse_cnt;
        beat(50);
        Rst = 1'b1;
        tick(1);
        Rst = 1'b0;
        check("rst_mid_data", int'(data_out), 0);
        wr_all(16'h0100, 16'h0100, 16'h0100);
        pixel("rst_mid", 7, 7, 7, 21);
        check("rst_mid_total", pulse_cnt - n0, 1);

`ifdef CONV1X1_BIAS_EN
        bias_we = 1'b1; bias_data = 32'h0000_0A00;
        tick(1);
        bias_we = 1'b0;
        pixel("bias", 1, 1, 1, 13);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
